// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM states and
// default timing/reset parameters used by the top level and the timer.
package fetch_pkg;

    // Default number of REQ cycles tolerated without mem_ack.
    localparam int unsigned FETCH_MAX_WAIT = 15;

    // Default program-counter reset address; mem_addr resets to this.
    localparam logic [31:0] FETCH_RESET_VEC = 32'd107;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of fetch-unit signals: PC handshake, instruction-memory bus,
// decode handshake and status. Suffixes are from the fetch unit's view.
interface instr_fetch_if;

    // Program counter side
    logic        en_i;
    logic [31:0] pc_addr_i;
    logic        pc_write_o;

    // Instruction memory side
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    // Decode side
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        flush_i;

    // Status
    logic        fetch_err_o;

    // The fetch unit itself.
    modport master (
        input  en_i, pc_addr_i, mem_ack_i, mem_rdata_i, instr_ready_i, flush_i,
        output pc_write_o, mem_req_o, mem_addr_o, instr_o, instr_valid_o,
        fetch_err_o
    );

    // The surrounding core / memory model.
    modport slave (
        output en_i, pc_addr_i, mem_ack_i, mem_rdata_i, instr_ready_i, flush_i,
        input  pc_write_o, mem_req_o, mem_addr_o, instr_o, instr_valid_o,
        fetch_err_o
    );

endinterface

// File: rtl/fetch_timer.sv
// Saturating wait counter for outstanding memory requests. expired_o is
// high when the count has reached MAX_WAIT, or will reach it on this edge,
// so the request is dropped after exactly MAX_WAIT unacknowledged cycles.
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_WAIT = FETCH_MAX_WAIT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise increment and saturate at MAX_WAIT.
    always_comb begin
        // NOTE: count_d takes a default first so this block can never infer a latch.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CNT_MAX) || (count_en_i && (count_q == CNT_LAST));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE -> REQ -> HOLD. Reads one instruction from
// memory at the PC, presents it to decode, pulses pc_write once, and
// handles branch flushes and memory timeouts. All outputs are registered.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = FETCH_MAX_WAIT,
    parameter logic [31:0] RESET_VEC = FETCH_RESET_VEC
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    instr_fetch_if.master bus
);

    fetch_state_e state_q;
    logic         mem_req_q;
    logic [31:0]  mem_addr_q;
    logic [31:0]  instr_q;
    logic         instr_valid_q;
    logic         pc_write_q;
    logic         fetch_err_q;
    logic         discard_q;

    logic start_fetch;
    logic timer_clear;
    logic timer_count_en;
    logic timer_expired;

    // A fetch may start only when enabled, not flushed and not in error.
    assign start_fetch    = bus.en_i && !bus.flush_i && !fetch_err_q;
    assign timer_clear    = (state_q == ST_IDLE) && start_fetch;
    assign timer_count_en = (state_q == ST_REQ) && !bus.mem_ack_i;

    fetch_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (timer_clear),
        .count_en_i (timer_count_en),
        .expired_o  (timer_expired)
    );

    // Fetch FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: instr is reset too because zero is its defined value out of reset.
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_VEC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_write_q    <= 1'b0;
            fetch_err_q   <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
            pc_write_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_fetch) begin
                        mem_addr_q <= bus.pc_addr_i;
                        mem_req_q  <= 1'b1;
                        discard_q  <= 1'b0;
                        state_q    <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (bus.mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        discard_q <= 1'b0;
                        if (bus.flush_i || discard_q) begin
                            // Branch taken while the read was in flight: drop it.
                            state_q <= ST_IDLE;
                        end else begin
                            instr_q       <= bus.mem_rdata_i;
                            instr_valid_q <= 1'b1;
                            pc_write_q    <= 1'b1;
                            state_q       <= ST_HOLD;
                        end
                    end else if (timer_expired) begin
                        mem_req_q   <= 1'b0;
                        fetch_err_q <= 1'b1;
                        discard_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (bus.flush_i) begin
                        // Keep the bus request stable; remember to drop its data.
                        discard_q <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    // A flush and an accept both retire the held word; with
                    // flush the word simply counts as not consumed.
                    if (bus.flush_i || bus.instr_ready_i) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end

                default: begin
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_o     = mem_req_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.instr_o       = instr_q;
    assign bus.instr_valid_o = instr_valid_q;
    assign bus.pc_write_o    = pc_write_q;
    assign bus.fetch_err_o   = fetch_err_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum REQ cycles without mem_ack before timeout.
REQ-002 Parameter RESET_VEC, default 107: reset value of mem_addr, equal to the program-counter reset address.
REQ-003 clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  fetch enable; sampled in IDLE only.
REQ-006 pc_addr  in  32  current instruction address from the program counter.
REQ-007 pc_write  out  1  one-cycle pulse commanding the program counter to load its next address.
REQ-008 mem_req  out  1  instruction-memory read request.
REQ-009 mem_addr  out  32  read address, registered.
REQ-010 mem_ack  in  1  memory read complete; mem_rdata valid in the same cycle.
REQ-011 mem_rdata  in  32  instruction word.
REQ-012 instr  out  32  fetched instruction to decode.
REQ-013 instr_valid  out  1  instr holds an unconsumed instruction.
REQ-014 instr_ready  in  1  decode accepts instr when high with instr_valid.
REQ-015 flush  in  1  discard in-flight or held instruction (branch taken).
REQ-016 fetch_err  out  1  sticky timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and HOLD; all outputs SHALL be registered.
REQ-018 IDLE: if en=1, flush=0 and fetch_err=0, then mem_addr<=pc_addr, mem_req<=1, wait counter<=0, and the FSM goes to REQ; otherwise it stays in IDLE.
REQ-019 REQ: mem_req and mem_addr SHALL stay stable until mem_ack; mem_ack in the first REQ cycle is legal.
REQ-020 REQ with mem_ack=1 and flush=0: instr<=mem_rdata, instr_valid<=1, mem_req<=0, pc_write<=1, and the FSM goes to HOLD.
REQ-021 pc_write SHALL be high for exactly one cycle, namely the first HOLD cycle.
REQ-022 HOLD: when instr_valid=1 and instr_ready=1, instr_valid<=0 and the FSM goes to IDLE; the minimum HOLD residency is one cycle, so the next IDLE->REQ edge latches the updated PC.
REQ-023 Fetch latency: mem_ack in cycle t gives instr_valid=1 from cycle t+1; the minimum period is 3 cycles per instruction with a zero-wait memory.
REQ-024 flush in REQ without mem_ack: a discard flag SHALL be set, and mem_req is held until mem_ack.
REQ-025 On mem_ack with flush=1 or the discard flag set: the data SHALL be dropped, there SHALL be no instr_valid and no pc_write, mem_req<=0, the flag is cleared, and the FSM goes to IDLE.
REQ-026 flush in HOLD: instr_valid<=0 and the FSM goes to IDLE, even if instr_ready=1 in the same cycle, which counts as not consumed.
REQ-027 flush in IDLE SHALL block a fetch start in that cycle and SHALL have no other effect.
REQ-028 The wait counter SHALL increment each REQ cycle without mem_ack, saturating at MAX_WAIT.
REQ-029 At count MAX_WAIT: mem_req<=0, fetch_err<=1, and the FSM goes to IDLE; fetch_err stays high until reset, and no new fetch starts while it is high.
REQ-030 mem_ack outside REQ SHALL be ignored.
REQ-031 A deasserted en SHALL not abort REQ or HOLD.

Reset
REQ-032 Asserting reset low at any time, including mid-REQ, SHALL force IDLE, mem_req=0, mem_addr=RESET_VEC, instr=0, instr_valid=0, pc_write=0, fetch_err=0, wait counter=0 and discard flag=0.
REQ-033 After reset deasserts, the first fetch SHALL begin on the first posedge with en=1.

Structure
REQ-034 The FSM state enumeration and the MAX_WAIT/RESET_VEC defaults SHALL live in the shared package fetch_pkg.
REQ-035 The wait counter SHALL be the sub-module fetch_timer, with ports clear, count_en, expired and the same reset.

Verification
REQ-036 Reset, en=1, pc_addr=107, mem_ack one cycle after mem_req with rdata=32'h2002000A -> mem_addr=107, instr=32'h2002000A, instr_valid=1, pc_write one-cycle pulse.
REQ-037 instr_ready=0 for 5 cycles, then 1 -> instr holds 32'h2002000A for all 6 cycles; instr_valid falls one cycle after acceptance; next mem_addr=108.
REQ-038 flush asserted in REQ, ack 2 cycles later -> no instr_valid, no pc_write, return to IDLE.
REQ-039 mem_ack never asserted -> after 15 REQ cycles mem_req=0, fetch_err=1, and no further mem_req while en=1.
REQ-040 reset pulsed low while in REQ with mem_ack arriving next cycle -> all outputs at reset values, ack ignored, mem_addr=107.
REQ-041 flush and instr_ready both high in HOLD -> instr_valid=0 next cycle, FSM in IDLE, no additional pc_write.
